// File: rtl/bus_pkg.sv
// Shared bus types for the node adapter.
// NUMNODES falls back to 4 when the build does not provide it.
`ifndef NUMNODES
`define NUMNODES 4
`endif

package bus_pkg;

  localparam int ADDR_W = 48;
  localparam int NODE_W = $clog2(`NUMNODES) + 1;

  typedef logic [NODE_W-1:0] node_id_t;

  typedef struct packed {
    node_id_t          dest;
    logic [ADDR_W-1:0] mem_address;
  } bus_req_t;

endpackage

// File: rtl/bus_node_if_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head reads 0 when empty.
// A push into a full FIFO only lands if a pop happens the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_d = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d = do_pop  ? rd_q + 1'b1 : rd_q;

  assign head_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/bus_node_if.sv
// Per-node bus endpoint: TX request queue and RX delivery buffer.
// Define BUS_NODE_IF_TIMEOUT_EN to add the tx_timeout watchdog.
module bus_node_if
  import bus_pkg::*;
#(
  parameter int NUM_PROC       = `NUMNODES,
  parameter int NODE_ID        = 0,
  parameter int TX_DEPTH       = 4,
  parameter int RX_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  input  logic [ADDR_W-1:0]         tx_addr,
  input  logic [$clog2(NUM_PROC):0] tx_dest,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [ADDR_W-1:0]         rx_addr,
  output logic                      bus_req_avail,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [$clog2(NUM_PROC):0] bus_dest,
  input  logic                      bus_processed,
  input  logic                      bus_deliver,
  input  logic [ADDR_W-1:0]         bus_deliver_addr,
  output logic [7:0]                rx_drop_cnt,
`ifdef BUS_NODE_IF_TIMEOUT_EN
  output logic                      tx_timeout,
`endif
  output logic                      proto_err
);

  localparam int  DW    = $clog2(NUM_PROC) + 1;
  localparam bit  ID_OK = (NODE_ID < NUM_PROC);

  bus_req_t tx_wr;
  bus_req_t tx_head;
  logic     tx_full, tx_empty;
  logic     tx_fire, tx_push, tx_pop;
  logic     dest_bad;

  logic     rx_full, rx_empty;
  logic     rx_push, rx_pop, rx_drop;

  logic       err_q, err_d;
  logic [7:0] drop_q, drop_d;

  assign tx_ready = rst_l && !tx_full;
  assign dest_bad = (tx_dest >= DW'(NUM_PROC));
  assign tx_fire  = tx_valid && tx_ready;
  assign tx_push  = tx_fire && !dest_bad;
  assign tx_pop   = bus_processed && !tx_empty;

  assign tx_wr.dest        = tx_dest;
  assign tx_wr.mem_address = tx_addr;

  sync_fifo #(
    .WIDTH ($bits(bus_req_t)),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (tx_wr),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

  assign bus_req_avail = !tx_empty;
  assign bus_addr      = tx_head.mem_address;
  assign bus_dest      = tx_head.dest;

  assign rx_pop  = rx_valid && rx_ready;
  assign rx_push = bus_deliver && (!rx_full || rx_pop);
  assign rx_drop = bus_deliver && rx_full && !rx_pop;

  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (bus_deliver_addr),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_addr)
  );

  assign rx_valid = !rx_empty;

  assign err_d  = err_q ||
                  (bus_processed && tx_empty) ||
                  (tx_fire && dest_bad);
  assign drop_d = (rx_drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

  // A NODE_ID outside the bus can never be addressed; flag it permanently.
  assign proto_err   = err_q || (rst_l && !ID_OK);
  assign rx_drop_cnt = drop_q;

`ifdef BUS_NODE_IF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_q, wait_d;
  logic          tmo_q, tmo_d;

  always_comb begin
    wait_d = wait_q;
    if (tx_empty || bus_processed) wait_d = '0;
    else if (wait_q != TW'(TIMEOUT_CYCLES)) wait_d = wait_q + 1'b1;
  end

  assign tmo_d = tmo_q || (wait_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wait_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tx_timeout = tmo_q;
`endif

endmodule

// File: tb/tb_bus_node_if.sv
// Scoreboard bench for bus_node_if (NUM_PROC=4, NODE_ID=1).
// Define BUS_NODE_IF_TIMEOUT_EN to also exercise the watchdog.
module tb_bus_node_if;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        tx_valid;
  logic        tx_ready;
  logic [47:0] tx_addr;
  logic [2:0]  tx_dest;
  logic        rx_valid;
  logic        rx_ready;
  logic [47:0] rx_addr;
  logic        bus_req_avail;
  logic [47:0] bus_addr;
  logic [2:0]  bus_dest;
  logic        bus_processed;
  logic        bus_deliver;
  logic [47:0] bus_deliver_addr;
  logic [7:0]  rx_drop_cnt;
  logic        proto_err;
`ifdef BUS_NODE_IF_TIMEOUT_EN
  logic        tx_timeout;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [50:0] txq [$];
  logic [47:0] rxq [$];
  int          exp_drop;
  logic        exp_err;

  always #5 clk = ~clk;

  bus_node_if #(
    .NUM_PROC (4),
    .NODE_ID  (1),
    .TX_DEPTH (4),
    .RX_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_addr          (tx_addr),
    .tx_dest          (tx_dest),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .rx_addr          (rx_addr),
    .bus_req_avail    (bus_req_avail),
    .bus_addr         (bus_addr),
    .bus_dest         (bus_dest),
    .bus_processed    (bus_processed),
    .bus_deliver      (bus_deliver),
    .bus_deliver_addr (bus_deliver_addr),
    .rx_drop_cnt      (rx_drop_cnt),
`ifdef BUS_NODE_IF_TIMEOUT_EN
    .tx_timeout       (tx_timeout),
`endif
    .proto_err        (proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state();
    logic [50:0] h;
    logic [47:0] r;
    h = (txq.size() != 0) ? txq[0] : '0;
    r = (rxq.size() != 0) ? rxq[0] : '0;
    chk("tx_ready", 64'(tx_ready), 64'(txq.size() < 4));
    chk("req_avail", 64'(bus_req_avail), 64'(txq.size() != 0));
    chk("bus_addr", 64'(bus_addr), 64'(h[47:0]));
    chk("bus_dest", 64'(bus_dest), 64'(h[50:48]));
    chk("rx_valid", 64'(rx_valid), 64'(rxq.size() != 0));
    chk("rx_addr", 64'(rx_addr), 64'(r));
    chk("drop_cnt", 64'(rx_drop_cnt), 64'(exp_drop));
    chk("proto_err", 64'(proto_err), 64'(exp_err));
  endtask

  // Predict the effect of the current inputs, then advance one edge.
  task automatic tick();
    bit tx_acc, tx_pop, rx_pop;
    tx_acc = tx_valid && (txq.size() < 4);
    tx_pop = bus_processed && (txq.size() != 0);
    rx_pop = rx_ready && (rxq.size() != 0);
    if (bus_processed && txq.size() == 0) exp_err = 1'b1;
    if (tx_acc && tx_dest >= 3'd4) exp_err = 1'b1;
    if (tx_pop) void'(txq.pop_front());
    if (tx_acc && tx_dest < 3'd4) txq.push_back({tx_dest, tx_addr});
    if (rx_pop) void'(rxq.pop_front());
    if (bus_deliver) begin
      if (rxq.size() < 4) rxq.push_back(bus_deliver_addr);
      else if (exp_drop < 255) exp_drop++;
    end
    @(posedge clk);
    #1;
    chk_state();
  endtask

  task automatic idle();
    tx_valid      = 1'b0;
    bus_processed = 1'b0;
    bus_deliver   = 1'b0;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    txq.delete();
    rxq.delete();
    exp_drop = 0;
    exp_err  = 1'b0;
    #1;
    chk("rst_ready", 64'(tx_ready), 64'd0);
    chk("rst_avail", 64'(bus_req_avail), 64'd0);
    chk("rst_rxv", 64'(rx_valid), 64'd0);
    chk("rst_err", 64'(proto_err), 64'd0);
    chk("rst_drop", 64'(rx_drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    #1;
    chk_state();
  endtask

  initial begin
    idle();
    rx_ready         = 1'b0;
    tx_addr          = '0;
    tx_dest          = '0;
    bus_deliver_addr = '0;
    do_reset();

    // single request held, then acknowledged
    tx_valid = 1'b1; tx_addr = 48'h1000; tx_dest = 3'd2;
    tick();
    idle();
    for (int i = 0; i < 21; i++) tick();
    bus_processed = 1'b1;
    tick();
    idle();
    tick();

    // fill, overflow attempt, ordered drain with push+pop overlap
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_addr = 48'hA0 + 48'(i); tx_dest = 3'(i);
      tick();
    end
    tx_addr = 48'hA4; tx_dest = 3'd1;
    chk("full_ready", 64'(tx_ready), 64'd0);
    tick();
    bus_processed = 1'b1;
    tick();
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    idle();
    tick();

    // single delivery
    bus_deliver = 1'b1; bus_deliver_addr = 48'hBEEF;
    tick();
    idle();
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();

    // overflow drops, then full+deliver+pop
    for (int i = 1; i <= 6; i++) begin
      bus_deliver = 1'b1; bus_deliver_addr = 48'(i);
      tick();
    end
    bus_deliver_addr = 48'h7; rx_ready = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();
    rx_ready = 1'b0;

    // protocol errors and reset recovery
    bus_processed = 1'b1;
    tick();
    idle();
    tx_valid = 1'b1; tx_addr = 48'h55; tx_dest = 3'd4;
    tick();
    idle();
    tick();
    tx_valid = 1'b1; tx_addr = 48'h66; tx_dest = 3'd1;
    bus_deliver = 1'b1; bus_deliver_addr = 48'h77;
    tick();
    idle();
    do_reset();

    // long-held request
    tx_valid = 1'b1; tx_addr = 48'h2222; tx_dest = 3'd3;
    tick();
    idle();
    for (int i = 0; i < 200; i++) @(posedge clk);
    #1;
`ifdef BUS_NODE_IF_TIMEOUT_EN
    chk("tmo_early", 64'(tx_timeout), 64'd0);
`endif
    for (int i = 0; i < 60; i++) @(posedge clk);
    #1;
    chk_state();
`ifdef BUS_NODE_IF_TIMEOUT_EN
    chk("tmo_set", 64'(tx_timeout), 64'd1);
`endif
    bus_processed = 1'b1;
    tick();
    idle();
    tick();
`ifdef BUS_NODE_IF_TIMEOUT_EN
    chk("tmo_sticky", 64'(tx_timeout), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
